// File: rtl/seq_divider_if.sv
// Operand and result handshake bundle for seq_divider.
// The divider connects through the slave modport and the operand source/result consumer through master.
interface seq_divider_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             is_signed;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport slave (
        input  in_valid, dividend, divisor, is_signed, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport master (
        output in_valid, dividend, divisor, is_signed, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Radix-2 restoring divider: one quotient bit per clock on operand magnitudes,
// with a final sign-fixup cycle for signed (truncate-toward-zero) operations.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        rstN,
    seq_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rmd_q, rmd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]        shifted;
    logic signed [WIDTH:0] trial;

    function automatic logic [WIDTH-1:0] cond_negate(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        return cond_negate(v, sgn && v[WIDTH-1]);
    endfunction

    always_comb begin
        state_d   = state_q;
        dvd_d     = dvd_q;
        dsr_d     = dsr_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        rmd_d     = rmd_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        dbz_d     = dbz_q;

        shifted = {rem_q, dvd_q[WIDTH-1]};
        trial   = signed'(shifted - {1'b0, dsr_q});

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d   = CALC;
                    dsr_d     = magnitude(bus.divisor, bus.is_signed);
                    // A zero divisor keeps the raw dividend so it can be returned as the remainder.
                    dvd_d     = (bus.divisor == '0) ? bus.dividend
                                                    : magnitude(bus.dividend, bus.is_signed);
                    rem_d     = '0;
                    cnt_d     = CW'(WIDTH - 1);
                    neg_quo_d = bus.is_signed && (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                    neg_rem_d = bus.is_signed && bus.dividend[WIDTH-1];
                end
            end
            CALC: begin
                if (dsr_q == '0) begin
                    quo_d   = '1;
                    rmd_d   = dvd_q;
                    dbz_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    rem_d = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                    dvd_d = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        state_d = FIXUP;
                    end
                end
            end
            FIXUP: begin
                quo_d   = cond_negate(dvd_q, neg_quo_q);
                rmd_d   = cond_negate(rem_q, neg_rem_q);
                dbz_d   = 1'b0;
                state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and visible results
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= IDLE;
            quo_q   <= '0;
            rmd_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            dbz_q   <= dbz_d;
        end
    end

    // Working datapath, reloaded on every accept
    always_ff @(posedge clk) begin
        dvd_q     <= dvd_d;
        dsr_q     <= dsr_d;
        rem_q     <= rem_d;
        cnt_q     <= cnt_d;
        neg_quo_q <= neg_quo_d;
        neg_rem_q <= neg_rem_d;
    end

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.out_valid   = (state_q == DONE);
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rmd_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed cases on an 8-bit instance plus back-to-back random
// streams on 2/8/16-bit instances, all scored against an arithmetic reference model.
module tb_seq_divider;
    typedef struct {
        longint unsigned q;
        longint unsigned r;
        bit              dbz;
        int              lat;
    } exp_t;

    logic clk = 1'b0;
    logic rstN = 1'b0;
    logic rst_bb_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   bb_done [3];
    exp_t exp8 [$];

    always #5 clk = ~clk;

    seq_divider_if #(.WIDTH(8)) d8 ();
    seq_divider #(.WIDTH(8)) u_dut8 (.clk(clk), .rstN(rstN), .bus(d8));

    task automatic check(input string nm, input longint unsigned act, input longint unsigned exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic timeout_fail(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out waiting for DUT", nm);
    endtask

    // Reference: plain integer division; SV signed '/' and '%' truncate toward zero.
    function automatic exp_t model(input int w, input longint unsigned a, input longint unsigned b, input bit s);
        exp_t e;
        longint unsigned mask;
        longint sa, sb;
        mask  = (64'd1 << w) - 64'd1;
        e.lat = w + 1;
        e.dbz = 1'b0;
        if (b == 0) begin
            e.q = mask; e.r = a; e.dbz = 1'b1; e.lat = 1;
        end else if (!s) begin
            e.q = a / b; e.r = a % b;
        end else begin
            sa  = $signed(a << (64 - w)) >>> (64 - w);
            sb  = $signed(b << (64 - w)) >>> (64 - w);
            e.q = $unsigned(sa / sb) & mask;
            e.r = $unsigned(sa % sb) & mask;
        end
        return e;
    endfunction

    // Scoreboard monitor for the directed instance
    always @(negedge clk) begin
        #1;
        if (d8.out_valid && d8.out_ready) begin
            if (exp8.size() == 0) begin
                timeout_fail("d8_unexpected_result");
            end else begin
                exp_t e;
                e = exp8.pop_front();
                check("d8_quotient", 64'(d8.quotient), e.q);
                check("d8_remainder", 64'(d8.remainder), e.r);
                check("d8_div_by_zero", 64'(d8.div_by_zero), 64'(e.dbz));
            end
        end
    end

    task automatic start8(input logic [7:0] a, input logic [7:0] b, input bit s);
        int t = 0;
        d8.dividend = a; d8.divisor = b; d8.is_signed = s; d8.in_valid = 1'b1;
        while (!d8.in_ready && t < 50) begin
            @(negedge clk); t++;
        end
        if (t >= 50) timeout_fail("d8_accept");
        exp8.push_back(model(8, 64'(a), 64'(b), s));
        @(negedge clk);
        d8.in_valid = 1'b0;
        d8.dividend = 8'($urandom); d8.divisor = 8'($urandom); d8.is_signed = 1'($urandom);
    endtask

    task automatic wait_result8(input int exp_lat, input string nm);
        int n = 0;
        bit ir = 1'b0;
        while (!d8.out_valid && n < 40) begin
            d8.in_valid = 1'($urandom);
            d8.dividend = 8'($urandom); d8.divisor = 8'($urandom); d8.is_signed = 1'($urandom);
            @(negedge clk); n++;
            if (d8.in_ready) ir = 1'b1;
        end
        check({nm, "_latency"}, 64'(n), 64'(exp_lat));
        check({nm, "_in_ready_busy"}, 64'(ir), 64'd0);
    endtask

    task automatic expect8(input string nm, input logic [7:0] q, input logic [7:0] r, input bit z);
        check({nm, "_q"}, 64'(d8.quotient), 64'(q));
        check({nm, "_r"}, 64'(d8.remainder), 64'(r));
        check({nm, "_dbz"}, 64'(d8.div_by_zero), 64'(z));
    endtask

    task automatic hold_release8(input int hold);
        logic [7:0] q0, r0;
        logic z0;
        bit bad = 1'b0;
        q0 = d8.quotient; r0 = d8.remainder; z0 = d8.div_by_zero;
        for (int i = 0; i < hold; i++) begin
            d8.in_valid = 1'b1; d8.dividend = 8'($urandom); d8.divisor = 8'($urandom);
            @(negedge clk);
            if (!d8.out_valid || d8.in_ready || d8.quotient !== q0 ||
                d8.remainder !== r0 || d8.div_by_zero !== z0) bad = 1'b1;
        end
        check("hold_stable", 64'(bad), 64'd0);
        d8.in_valid = 1'b0; d8.out_ready = 1'b1;
        @(negedge clk);
        d8.out_ready = 1'b0;
        check("post_handshake_in_ready", 64'(d8.in_ready), 64'd1);
        check("post_handshake_out_valid", 64'(d8.out_valid), 64'd0);
    endtask

    // Back-to-back random streams with out_ready tied high
    for (genvar g = 0; g < 3; g++) begin : g_bb
        localparam int W = (g == 0) ? 2 : ((g == 1) ? 8 : 16);
        seq_divider_if #(.WIDTH(W)) bif ();
        seq_divider #(.WIDTH(W)) u_dut (.clk(clk), .rstN(rst_bb_n), .bus(bif));
        exp_t q_exp [$];
        int   cyc = 0;
        int   last_hs = -1;

        always @(posedge clk) cyc <= cyc + 1;

        initial begin
            logic [W-1:0] a, b;
            bit s;
            int t;
            bif.in_valid = 1'b0; bif.out_ready = 1'b1;
            bif.dividend = '0; bif.divisor = '0; bif.is_signed = 1'b0;
            wait (rst_bb_n);
            @(negedge clk);
            for (int i = 0; i < 20; i++) begin
                a = W'($urandom);
                b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
                s = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 9) == 0) begin
                    a = {1'b1, {(W-1){1'b0}}}; b = '1; s = 1'b1;
                end
                bif.dividend = a; bif.divisor = b; bif.is_signed = s; bif.in_valid = 1'b1;
                t = 0;
                while (!bif.in_ready && t < 100) begin
                    @(negedge clk); t++;
                end
                if (t >= 100) timeout_fail($sformatf("w%0d_accept", W));
                q_exp.push_back(model(W, 64'(a), 64'(b), s));
                @(negedge clk);
            end
            bif.in_valid = 1'b0;
            t = 0;
            while (q_exp.size() != 0 && t < 200) begin
                @(negedge clk); t++;
            end
            if (t >= 200) timeout_fail($sformatf("w%0d_drain", W));
            bb_done[g] = 1'b1;
        end

        always @(negedge clk) begin
            #1;
            if (bif.out_valid && bif.out_ready) begin
                if (q_exp.size() == 0) begin
                    timeout_fail($sformatf("w%0d_unexpected_result", W));
                end else begin
                    exp_t e;
                    e = q_exp.pop_front();
                    check($sformatf("w%0d_quotient", W), 64'(bif.quotient), e.q);
                    check($sformatf("w%0d_remainder", W), 64'(bif.remainder), e.r);
                    check($sformatf("w%0d_div_by_zero", W), 64'(bif.div_by_zero), 64'(e.dbz));
                    if (last_hs >= 0)
                        check($sformatf("w%0d_spacing", W), 64'(cyc - last_hs), 64'(e.lat + 2));
                    last_hs = cyc;
                end
            end
        end
    end

    initial begin
        int t;
        d8.in_valid = 1'b0; d8.out_ready = 1'b0;
        d8.dividend = '0; d8.divisor = '0; d8.is_signed = 1'b0;
        @(negedge clk);
        check("reset_in_ready", 64'(d8.in_ready), 64'd1);
        check("reset_out_valid", 64'(d8.out_valid), 64'd0);
        expect8("reset", 8'h00, 8'h00, 1'b0);
        rstN = 1'b1;
        rst_bb_n = 1'b1;
        @(negedge clk);

        start8(8'd100, 8'd7, 1'b0);
        wait_result8(9, "u100_7");
        expect8("u100_7", 8'd14, 8'd2, 1'b0);
        hold_release8(1);

        start8(8'h9C, 8'h07, 1'b1);
        wait_result8(9, "sm100_7");
        expect8("sm100_7", 8'hF2, 8'hFE, 1'b0);
        hold_release8(1);

        start8(8'h64, 8'hF9, 1'b1);
        wait_result8(9, "s100_m7");
        expect8("s100_m7", 8'hF2, 8'h02, 1'b0);
        hold_release8(1);

        start8(8'h80, 8'hFF, 1'b1);
        wait_result8(9, "s_overflow");
        expect8("s_overflow", 8'h80, 8'h00, 1'b0);
        hold_release8(1);

        start8(8'h55, 8'h00, 1'b0);
        wait_result8(1, "u_div0");
        expect8("u_div0", 8'hFF, 8'h55, 1'b1);
        hold_release8(1);

        start8(8'h55, 8'h00, 1'b1);
        wait_result8(1, "s_div0");
        expect8("s_div0", 8'hFF, 8'h55, 1'b1);
        hold_release8(1);

        start8(8'd200, 8'd13, 1'b0);
        wait_result8(9, "backpressure");
        expect8("backpressure", 8'd15, 8'd5, 1'b0);
        hold_release8(5);

        // Asynchronous reset part-way through CALC discards the operation
        start8(8'd200, 8'd3, 1'b0);
        void'(exp8.pop_back());
        repeat (3) @(negedge clk);
        #2 rstN = 1'b0;
        #1;
        check("midcalc_reset_in_ready", 64'(d8.in_ready), 64'd1);
        check("midcalc_reset_out_valid", 64'(d8.out_valid), 64'd0);
        expect8("midcalc_reset", 8'h00, 8'h00, 1'b0);
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);

        start8(8'd255, 8'd1, 1'b0);
        wait_result8(9, "after_reset");
        expect8("after_reset", 8'd255, 8'd0, 1'b0);
        hold_release8(1);

        t = 0;
        while (!(bb_done[0] && bb_done[1] && bb_done[2]) && t < 5000) begin
            @(negedge clk); t++;
        end
        if (t >= 5000) timeout_fail("back_to_back_streams");
        check("d8_scoreboard_empty", 64'(exp8.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
